// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - MM:SS BCD timer with shift-load, start/pause, down/up count and done pulse
// Define TIMER_AUTORELOAD_EN to reload the preset latched at start instead of stopping in DONE.
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV   = 1,
  parameter bit          UP_MODE_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] in,
  input  logic       start,
  input  logic       pause,
  input  logic       dir,
  output logic [3:0] out_second_unit,
  output logic [3:0] out_second_tens,
  output logic [3:0] out_minute_unit,
  output logic [3:0] out_minute_tens,
  output logic       running,
  output logic       finished,
  output logic       done_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] digits, digits_nxt;  // {minute_tens, minute_unit, second_tens, second_unit}
  logic [15:0] presc, presc_nxt;
  logic        dir_q, dir_nxt;
  logic        done_nxt;
  logic [15:0] shifted, stepped;
  logic        start_dir, tick;
`ifdef TIMER_AUTORELOAD_EN
  logic [15:0] preset_q, preset_nxt;
  logic        reload_q, reload_nxt;
`endif

  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [15:0] terminal(input logic up);
    return up ? 16'h5959 : 16'h0000;
  endfunction

  // Single-step increment/decrement; carry or borrow ripples through all four digits in one cycle.
  function automatic logic [15:0] bcd_step(input logic [15:0] d, input logic up);
    logic [15:0] r;
    logic [3:0]  lim;
    logic        ripple;
    r      = d;
    ripple = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim = (i % 2 == 1) ? 4'd5 : 4'd9;
      if (ripple) begin
        if (up) begin
          ripple       = (d[4*i +: 4] == lim);
          r[4*i +: 4]  = ripple ? 4'd0 : d[4*i +: 4] + 4'd1;
        end else begin
          ripple       = (d[4*i +: 4] == 4'd0);
          r[4*i +: 4]  = ripple ? lim : d[4*i +: 4] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign shifted   = {sat(digits[11:8], 4'd5), sat(digits[7:4], 4'd9), sat(digits[3:0], 4'd5), sat(in, 4'd9)};
  assign stepped   = bcd_step(digits, dir_q);
  assign start_dir = UP_MODE_EN ? dir : 1'b0;
  assign tick      = (presc == PRESC_MAX);

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    presc_nxt  = presc;
    dir_nxt    = dir_q;
    done_nxt   = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    preset_nxt = preset_q;
    reload_nxt = 1'b0;
`endif
    case (state)
      IDLE, PAUSED: begin
        if (load) begin
          digits_nxt = shifted;
        end else if (start && !pause) begin
          dir_nxt = start_dir;
`ifdef TIMER_AUTORELOAD_EN
          preset_nxt = digits;
`endif
          if (digits == terminal(start_dir)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
`ifdef TIMER_AUTORELOAD_EN
        if (reload_q) begin
          digits_nxt = preset_q;
          presc_nxt  = '0;
        end else
`endif
        if (tick) begin
          presc_nxt  = '0;
          digits_nxt = stepped;
          if (stepped == terminal(dir_q)) begin
            done_nxt = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            reload_nxt = 1'b1;
`else
            state_nxt = DONE;
`endif
          end
        end else begin
          presc_nxt = presc + 16'd1;
        end
        // Reaching the terminal value wins over a simultaneous pause.
        if (pause && state_nxt == RUN) state_nxt = PAUSED;
      end
      DONE: begin
        if (load) begin
          digits_nxt = shifted;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      digits     <= '0;
      presc      <= '0;
      dir_q      <= 1'b0;
      done_pulse <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      preset_q   <= '0;
      reload_q   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      digits     <= digits_nxt;
      presc      <= presc_nxt;
      dir_q      <= dir_nxt;
      done_pulse <= done_nxt;
`ifdef TIMER_AUTORELOAD_EN
      preset_q   <= preset_nxt;
      reload_q   <= reload_nxt;
`endif
    end
  end

  assign {out_minute_tens, out_minute_unit, out_second_tens, out_second_unit} = digits;
  assign running  = (state == RUN);
  assign finished = (state == DONE);

endmodule
